// File: rtl/tube_host_master.sv
// Host-side master for a Tube-style mailbox: polls the FIFO status register,
// then performs one data transfer per command and returns a single response.
module tube_host_master #(
  parameter logic [15:0] POLL_LIMIT = 16'd1000
) (
  input  logic       h_phi2,
  input  logic       h_rst_b,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_reg,
  input  logic       cmd_write,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_err,
  output logic [2:0] h_addr,
  output logic       h_cs_b,
  output logic       h_rdnw,
  output logic [7:0] h_data_out,
  input  logic [7:0] h_data_in
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POLL = 2'd1,
    XFER = 2'd2,
    RESP = 2'd3
  } state_t;

  // A limit of zero still performs a single poll.
  localparam logic [15:0] LIMIT_EFF = (POLL_LIMIT == 16'd0) ? 16'd1 : POLL_LIMIT;

  function automatic logic [2:0] status_addr(input logic [1:0] idx);
    return {idx, 1'b0};
  endfunction

  function automatic logic [2:0] data_addr(input logic [1:0] idx);
    return {idx, 1'b1};
  endfunction

  // Writes wait for "not full" (bit 6), reads wait for "data available" (bit 7).
  function automatic logic status_ready(input logic [7:0] status, input logic wr);
    return wr ? status[6] : status[7];
  endfunction

  state_t      state_r, state_nxt_s;
  logic [15:0] poll_cnt_r, poll_cnt_nxt_s, poll_cnt_inc_s;
  logic [1:0]  idx_r, idx_nxt_s;
  logic        write_r, write_nxt_s;
  logic [7:0]  wdata_r, wdata_nxt_s;
  logic        cmd_ready_r, cmd_ready_nxt_s;
  logic        rsp_valid_r, rsp_valid_nxt_s;
  logic        rsp_err_r, rsp_err_nxt_s;
  logic [7:0]  rsp_data_r, rsp_data_nxt_s;
  logic [2:0]  h_addr_r, h_addr_nxt_s;
  logic        h_cs_b_r, h_cs_b_nxt_s;
  logic        h_rdnw_r, h_rdnw_nxt_s;
  logic [7:0]  h_data_out_r, h_data_out_nxt_s;
  logic        accept_s;

  assign accept_s       = cmd_valid & cmd_ready_r;
  assign poll_cnt_inc_s = poll_cnt_r + 16'd1;

  // Next-state and next-register computation; the bus is idle unless a cycle is issued.
  always_comb begin
    state_nxt_s      = state_r;
    poll_cnt_nxt_s   = poll_cnt_r;
    idx_nxt_s        = idx_r;
    write_nxt_s      = write_r;
    wdata_nxt_s      = wdata_r;
    rsp_valid_nxt_s  = rsp_valid_r;
    rsp_err_nxt_s    = rsp_err_r;
    rsp_data_nxt_s   = rsp_data_r;
    h_addr_nxt_s     = 3'd0;
    h_cs_b_nxt_s     = 1'b1;
    h_rdnw_nxt_s     = 1'b1;
    h_data_out_nxt_s = 8'h00;

    case (state_r)
      IDLE: begin
        if (accept_s) begin
          poll_cnt_nxt_s = 16'd0;
          idx_nxt_s      = cmd_reg[1:0] - 2'd1;
          write_nxt_s    = cmd_write;
          wdata_nxt_s    = cmd_wdata;
          rsp_data_nxt_s = 8'h00;
          rsp_err_nxt_s  = 1'b0;
          case (cmd_reg)
            3'd0: begin
              // Control register write: no handshake with the status flags.
              write_nxt_s      = 1'b1;
              state_nxt_s      = XFER;
              h_cs_b_nxt_s     = 1'b0;
              h_addr_nxt_s     = 3'd0;
              h_rdnw_nxt_s     = 1'b0;
              h_data_out_nxt_s = cmd_wdata;
            end
            3'd1, 3'd2, 3'd3, 3'd4: begin
              state_nxt_s  = POLL;
              h_cs_b_nxt_s = 1'b0;
              h_addr_nxt_s = status_addr(cmd_reg[1:0] - 2'd1);
              h_rdnw_nxt_s = 1'b1;
            end
            default: begin
              state_nxt_s     = RESP;
              rsp_valid_nxt_s = 1'b1;
              rsp_err_nxt_s   = 1'b1;
            end
          endcase
        end else begin
          state_nxt_s = IDLE;
        end
      end

      POLL: begin
        if (status_ready(h_data_in, write_r)) begin
          state_nxt_s      = XFER;
          h_cs_b_nxt_s     = 1'b0;
          h_addr_nxt_s     = data_addr(idx_r);
          h_rdnw_nxt_s     = ~write_r;
          h_data_out_nxt_s = write_r ? wdata_r : 8'h00;
        end else if (poll_cnt_inc_s >= LIMIT_EFF) begin
          poll_cnt_nxt_s  = poll_cnt_inc_s;
          state_nxt_s     = RESP;
          rsp_valid_nxt_s = 1'b1;
          rsp_err_nxt_s   = 1'b1;
          rsp_data_nxt_s  = 8'h00;
        end else begin
          poll_cnt_nxt_s = poll_cnt_inc_s;
          h_cs_b_nxt_s   = 1'b0;
          h_addr_nxt_s   = status_addr(idx_r);
          h_rdnw_nxt_s   = 1'b1;
        end
      end

      XFER: begin
        state_nxt_s     = RESP;
        rsp_valid_nxt_s = 1'b1;
        rsp_err_nxt_s   = 1'b0;
        rsp_data_nxt_s  = write_r ? 8'h00 : h_data_in;
      end

      RESP: begin
        if (rsp_ready) begin
          state_nxt_s     = IDLE;
          rsp_valid_nxt_s = 1'b0;
          rsp_err_nxt_s   = 1'b0;
        end else begin
          state_nxt_s = RESP;
        end
      end

      default: begin
        state_nxt_s     = IDLE;
        rsp_valid_nxt_s = 1'b0;
        rsp_err_nxt_s   = 1'b0;
      end
    endcase

    cmd_ready_nxt_s = (state_nxt_s == IDLE);
  end

  // State and registered outputs; reset releases the bus immediately.
  always_ff @(posedge h_phi2 or negedge h_rst_b) begin
    if (!h_rst_b) begin
      state_r      <= IDLE;
      poll_cnt_r   <= 16'd0;
      idx_r        <= 2'd0;
      write_r      <= 1'b0;
      wdata_r      <= 8'h00;
      cmd_ready_r  <= 1'b0;
      rsp_valid_r  <= 1'b0;
      rsp_err_r    <= 1'b0;
      rsp_data_r   <= 8'h00;
      h_addr_r     <= 3'd0;
      h_cs_b_r     <= 1'b1;
      h_rdnw_r     <= 1'b1;
      h_data_out_r <= 8'h00;
    end else begin
      state_r      <= state_nxt_s;
      poll_cnt_r   <= poll_cnt_nxt_s;
      idx_r        <= idx_nxt_s;
      write_r      <= write_nxt_s;
      wdata_r      <= wdata_nxt_s;
      cmd_ready_r  <= cmd_ready_nxt_s;
      rsp_valid_r  <= rsp_valid_nxt_s;
      rsp_err_r    <= rsp_err_nxt_s;
      rsp_data_r   <= rsp_data_nxt_s;
      h_addr_r     <= h_addr_nxt_s;
      h_cs_b_r     <= h_cs_b_nxt_s;
      h_rdnw_r     <= h_rdnw_nxt_s;
      h_data_out_r <= h_data_out_nxt_s;
    end
  end

  assign cmd_ready  = cmd_ready_r;
  assign rsp_valid  = rsp_valid_r;
  assign rsp_err    = rsp_err_r;
  assign rsp_data   = rsp_data_r;
  assign h_addr     = h_addr_r;
  assign h_cs_b     = h_cs_b_r;
  assign h_rdnw     = h_rdnw_r;
  assign h_data_out = h_data_out_r;

endmodule

// File: doc/tube_host_master.md
TUBE_HOST_MASTER -- requirements
Module: tube_host_master

Interface
REQ-001 SHALL have parameter POLL_LIMIT, default 16'd1000: maximum status polls per command before the command is abandoned.
REQ-002 SHALL have port h_phi2, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port h_rst_b, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port cmd_valid, input, 1 bit: a command is offered.
REQ-005 SHALL have port cmd_ready, output, 1 bit: the offered command is accepted this cycle.
REQ-006 SHALL have port cmd_reg, input, 3 bits: 0 = control/status register; 1..4 = FIFO register 1..4; 5..7 = illegal.
REQ-007 SHALL have port cmd_write, input, 1 bit: 1 = write, 0 = read.
REQ-008 SHALL have port cmd_wdata, input, 8 bits: write data, or control flags (S,T,P,V,M,J,I,Q) when cmd_reg = 0.
REQ-009 SHALL have port rsp_valid, output, 1 bit: a response is available.
REQ-010 SHALL have port rsp_ready, input, 1 bit: the consumer accepts the response.
REQ-011 SHALL have port rsp_data, output, 8 bits: read data; 8'h00 for writes and errors.
REQ-012 SHALL have port rsp_err, output, 1 bit: poll timeout or illegal register.
REQ-013 SHALL have port h_addr, output, 3 bits: host bus address.
REQ-014 SHALL have port h_cs_b, output, 1 bit: active-low tube select.
REQ-015 SHALL have port h_rdnw, output, 1 bit: 1 = read cycle.
REQ-016 SHALL have port h_data_out, output, 8 bits: write data to the tube.
REQ-017 SHALL have port h_data_in, input, 8 bits: read data from the tube.

Function
REQ-018 SHALL hold h_addr, h_cs_b, h_rdnw and h_data_out in registers; a bus cycle lasts exactly one clock with these stable, and read data is sampled at the rising edge that ends the cycle.
REQ-019 SHALL drive h_cs_b = 1 in every cycle with no bus cycle (idle: h_addr = 0, h_rdnw = 1, h_data_out = 0).
REQ-020 SHALL implement states IDLE, POLL, XFER and RESP.
REQ-021 SHALL assert cmd_ready only in IDLE; a command is accepted on cmd_valid & cmd_ready.
REQ-022 SHALL, on accepting cmd_reg = 0, go to XFER and issue one write to address 0 with h_data_out = cmd_wdata, without polling; cmd_write is ignored.
REQ-023 SHALL, on accepting cmd_reg = 5..7, go directly to RESP with rsp_err = 1 and issue no bus cycle.
REQ-024 SHALL, on accepting FIFO register n (1..4), go to POLL and issue a read to status address 2*(n-1).
REQ-025 SHALL, in POLL, advance to XFER when the sampled status shows ready: bit 6 (not full) for writes, bit 7 (data available) for reads; otherwise issue another status read in the next cycle.
REQ-026 SHALL issue the XFER bus cycle to data address 2*(n-1)+1 in the cycle immediately after the ready status sample; back-to-back bus cycles are permitted.
REQ-027 SHALL count polls with a 16-bit counter cleared on acceptance; when POLL_LIMIT not-ready samples have been seen, go to RESP with rsp_err = 1 and issue no data cycle.
REQ-028 SHALL capture h_data_in into rsp_data at the end of the read XFER cycle.
REQ-029 SHALL hold RESP with rsp_valid = 1 and stable rsp_data/rsp_err until rsp_ready; on rsp_valid & rsp_ready, return to IDLE, clear rsp_valid and clear rsp_err.
REQ-030 SHALL, with the first poll ready, assert rsp_valid 3 clocks after acceptance (acceptance edge = clock 0, status cycle = 1, data cycle = 2, rsp_valid at 3); a control write asserts rsp_valid 2 clocks after acceptance.
REQ-031 SHALL never issue more than one data cycle per command, and never a data cycle for a timed-out or illegal command.
REQ-032 SHALL treat POLL_LIMIT = 0 as 1 (a single poll).

Reset
REQ-033 SHALL, while h_rst_b = 0, force state IDLE, cmd_ready = 0, rsp_valid = 0, rsp_data = 0, rsp_err = 0, poll counter = 0, h_cs_b = 1, h_addr = 0, h_rdnw = 1, h_data_out = 0, independent of the clock.
REQ-034 SHALL, on reset asserted mid-command, abandon the command with no response and deassert h_cs_b immediately (asynchronously).
REQ-035 SHALL assert cmd_ready from the first rising edge after h_rst_b deasserts.

Verification
REQ-036 Write 8'hA5 to reg 1 with the tube not full -> status read at addr 0, write at addr 1 with data A5, rsp_valid at clock 3, rsp_err = 0.
REQ-037 Read reg 4 with the data-available flag set on the 3rd poll -> three status reads at addr 6, then a read at addr 7; rsp_data = the tube byte; rsp_valid at clock 5.
REQ-038 Read reg 2 with POLL_LIMIT = 4 and the tube never ready -> exactly 4 status reads at addr 2, no data cycle, rsp_err = 1, rsp_data = 00.
REQ-039 Control command cmd_wdata = 8'h92 -> a single write to addr 0 with data 92 and no poll; rsp_valid at clock 2.
REQ-040 cmd_reg = 6 -> no bus cycle, rsp_err = 1; with rsp_ready held low for 10 clocks, the response stays stable and cmd_ready stays 0.
REQ-041 h_rst_b pulsed low during POLL -> h_cs_b = 1 immediately, rsp_valid = 0; a new command is accepted normally afterward.
